// File: rtl/hazard_perf_pkg.sv
// Shared definitions for the hazard performance monitor: counter indices and trace record layout.
// Pure declarations; no logic, no latency.
package hazard_perf_pkg;

    localparam int NUM_CNT         = 8;

    localparam int CNT_CYCLES      = 0;
    localparam int CNT_STALLS      = 1;
    localparam int CNT_BRANCHES    = 2;
    localparam int CNT_FWD_A       = 3;
    localparam int CNT_FWD_B       = 4;
    localparam int CNT_FLUSH_IFID  = 5;
    localparam int CNT_FLUSH_IDEX  = 6;
    localparam int CNT_DROPS       = 7;

    typedef struct packed {
        logic [31:0] cycle;
        logic [31:0] target;
    } trace_rec_t;

endpackage

// File: rtl/hazard_perf_monitor_trace_fifo.sv
// Synchronous FIFO with wrap-bit pointers; a write is visible one edge later (no fall-through).
// A push into a full FIFO succeeds only when a pop happens on the same edge.
module trace_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] dout
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_q, wr_d, rd_q, rd_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push, do_pop;

    assign empty   = (wr_q == rd_q);
    assign full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    // Head reads as zero when empty so the record outputs idle at 0.
    assign dout    = empty ? '0 : mem_q[rd_q[AW-1:0]];

    always_comb begin
        wr_d = wr_q;
        rd_d = rd_q;
        if (clr) begin
            wr_d = '0;
            rd_d = '0;
        end else begin
            if (do_push) wr_d = wr_q + (AW+1)'(1);
            if (do_pop)  rd_d = rd_q + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !clr) mem_q[wr_q[AW-1:0]] <= din;
    end

endmodule

// File: rtl/hazard_perf_monitor.sv
// Saturating pipeline-hazard event counters with snapshot readout (1-cycle latency) and a taken-branch trace FIFO.
// Trace drains on valid/ready; records arriving while full with no pop are dropped and counted.
module hazard_perf_monitor
    import hazard_perf_pkg::*;
#(
    parameter int CNT_W       = 32,
    parameter int TRACE_DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        clr,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic [1:0]  forwardA,
    input  logic [1:0]  forwardB,
    input  logic        flush_IFID,
    input  logic        flush_IDEX,
    input  logic        snap,
    input  logic [2:0]  cnt_sel,
    output logic [31:0] cnt_data,
    output logic        trc_valid,
    input  logic        trc_ready,
    output logic [31:0] trc_cycle,
    output logic [31:0] trc_target,
    output logic        trc_overflow
);

    logic [CNT_W-1:0]   live_q   [NUM_CNT];
    logic [CNT_W-1:0]   live_d   [NUM_CNT];
    logic [CNT_W-1:0]   shadow_q [NUM_CNT];
    logic [31:0]        cnt_data_q;
    logic               ovf_q, ovf_d;
    logic [NUM_CNT-1:0] ev;

    logic       fifo_full, fifo_empty, push_req, pop, drop;
    trace_rec_t rec_in, rec_out;

    assign push_req = en & branch_taken & ~clr;
    assign pop      = ~fifo_empty & trc_ready;
    assign drop     = push_req & fifo_full & ~pop;

    assign rec_in.cycle  = 32'(live_q[CNT_CYCLES]);
    assign rec_in.target = branch_target;

    trace_fifo #(
        .WIDTH ($bits(trace_rec_t)),
        .DEPTH (TRACE_DEPTH)
    ) u_trace_fifo (
        .clk   (clk),
        .rst   (rst),
        .clr   (clr),
        .push  (push_req),
        .pop   (pop),
        .din   (rec_in),
        .full  (fifo_full),
        .empty (fifo_empty),
        .dout  (rec_out)
    );

    always_comb begin
        ev                 = '0;
        ev[CNT_CYCLES]     = en;
        ev[CNT_STALLS]     = en & stall;
        ev[CNT_BRANCHES]   = en & branch_taken;
        ev[CNT_FWD_A]      = en & (forwardA != 2'b00);
        ev[CNT_FWD_B]      = en & (forwardB != 2'b00);
        ev[CNT_FLUSH_IFID] = en & flush_IFID;
        ev[CNT_FLUSH_IDEX] = en & flush_IDEX;
        ev[CNT_DROPS]      = drop;
    end

    always_comb begin
        for (int i = 0; i < NUM_CNT; i++) begin
            live_d[i] = live_q[i];
            if (clr)
                live_d[i] = '0;
            else if (ev[i] && (live_q[i] != {CNT_W{1'b1}}))
                live_d[i] = live_q[i] + CNT_W'(1);
        end
        ovf_d = clr ? 1'b0 : (ovf_q | drop);
    end

    // Shadow copies the pre-edge live values, so a same-edge clr or increment never leaks in.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_CNT; i++) begin
                live_q[i]   <= '0;
                shadow_q[i] <= '0;
            end
            cnt_data_q <= '0;
            ovf_q      <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_CNT; i++) begin
                live_q[i] <= live_d[i];
                if (snap) shadow_q[i] <= live_q[i];
            end
            cnt_data_q <= 32'(shadow_q[cnt_sel]);
            ovf_q      <= ovf_d;
        end
    end

    assign cnt_data     = cnt_data_q;
    assign trc_valid    = ~fifo_empty;
    assign trc_cycle    = rec_out.cycle;
    assign trc_target   = rec_out.target;
    assign trc_overflow = ovf_q;

endmodule

// File: doc/hazard_perf_monitor.md
Name: hazard_perf_monitor

Overview:
- Synthesizable event monitor next to the 5-stage pipeline CPU core. It consumes the core's hazard signals: stall, branch_taken/branch_target, forwardA/forwardB and flush_IFID/flush_IDEX.
- Keeps saturating per-event counters, readable through a snapshot/select port.
- Buffers taken-branch records in a small trace FIFO drained by a valid/ready handshake.
- Replaces simulation-only $display monitoring with hardware that can be read on the board.

Parameters:
- CNT_W, 32: width of each event counter (1..32). cnt_data is zero-extended to 32.
- TRACE_DEPTH, 8: trace FIFO entries; power of two, ≥2.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  counting enable. Events are ignored when low.
- clr  in  1  synchronous clear of counters, FIFO and overflow flag.
- stall  in  1  pipeline stall from hazard unit.
- branch_taken  in  1  taken branch/jump resolved this cycle.
- branch_target  in  32  target PC for branch_taken.
- forwardA  in  2  ALU operand A forward select; nonzero means forwarding.
- forwardB  in  2  ALU operand B forward select; nonzero means forwarding.
- flush_IFID  in  1  IF/ID flush.
- flush_IDEX  in  1  ID/EX flush.
- snap  in  1  copy live counters into shadow registers.
- cnt_sel  in  3  shadow counter select.
- cnt_data  out  32  registered shadow[cnt_sel], zero-extended.
- trc_valid  out  1  FIFO head holds a record.
- trc_ready  in  1  consumer accepts head.
- trc_cycle  out  32  head record cycle stamp.
- trc_target  out  32  head record branch target.
- trc_overflow  out  1  sticky: at least one record dropped.

Behaviour:
- Reset (async, rst=1): all live and shadow counters 0, cnt_data 0, FIFO empty, trc_valid 0, trc_cycle/trc_target 0, trc_overflow 0. Recovery is on the first rising edge after rst falls. Reset mid-operation discards FIFO contents.
- Counter indices (live and shadow):
  - 0 CYCLES: +1 every cycle with en=1.
  - 1 STALLS: en & stall.
  - 2 BRANCHES: en & branch_taken.
  - 3 FWD_A: en & (forwardA != 0).
  - 4 FWD_B: en & (forwardB != 0).
  - 5 FLUSH_IFID: en & flush_IFID.
  - 6 FLUSH_IDEX: en & flush_IDEX.
  - 7 DROPS: trace records lost to a full FIFO.
- Counter rules:
  - Each counter saturates at 2^CNT_W−1 and never wraps.
  - All eight update in parallel on the same edge; any combination of events may coincide.
- clr priority:
  - clr=1 zeroes live counters, empties the FIFO and clears trc_overflow. Shadow registers are untouched.
  - Events in the clr cycle are discarded.
  - clr wins over snap: the shadow receives the pre-clear live values.
- Snapshot and read:
  - snap=1: on that edge shadow[i] ← live[i] as sampled before the same-edge increment.
  - cnt_data ← shadow[cnt_sel] every edge, giving 1-cycle read latency.
- Trace push:
  - Condition: en & branch_taken & ~clr.
  - Record = {cycle stamp, branch_target}. The stamp is the CYCLES value before this edge's increment, so the first enabled cycle stamps 0.
  - If the FIFO is full and no pop occurs on the same edge, the record is dropped, DROPS increments and trc_overflow is set.
- Trace pop:
  - Occurs on trc_valid & trc_ready.
  - trc_valid, trc_cycle and trc_target are combinational from the head. Head data is stable while valid & ~ready.
- FIFO boundaries:
  - Push and pop on the same edge while full: both succeed, no drop, occupancy unchanged.
  - Push and pop on the same edge while empty: only the push takes effect; the record becomes visible the next cycle (no fall-through).
  - Pointers are log2(TRACE_DEPTH)+1 bits with a wrap bit. Full and empty are derived from pointer compare.
  - Ordering is strict FIFO across pointer wrap-around.
- No state machine beyond FIFO occupancy. Combinational paths are limited to the FIFO head outputs.

Decomposition:
- Package hazard_perf_pkg:
  - counter index constants CNT_CYCLES..CNT_DROPS (0..7);
  - NUM_CNT=8;
  - trace record struct {cycle[31:0], target[31:0]}.
- Sub-module trace_fifo: parameterized synchronous FIFO (WIDTH=64, DEPTH) with push/pop/full/empty. Drop and overflow logic lives in the parent.

Test Plan:
- Reset: assert rst mid-run with 3 records queued → trc_valid=0, trc_overflow=0 immediately. After release, snap then read sel 0..7 → all 0.
- Counting: en=1 for 10 cycles, stall high on 3, forwardA=2'b10 on 2, forwardB=2'b01 on 1 → after snap, sel0=10, sel1=3, sel3=2, sel4=1, sel5=sel6=0. Each value appears one cycle after cnt_sel changes.
- Trace handshake: branch_taken on the 6th enabled cycle, target 0x0000_0040, trc_ready=0 → next cycle trc_valid=1, trc_cycle=5, trc_target=0x40, held for 4 cycles. Pulse trc_ready → trc_valid=0 next cycle.
- Overflow: TRACE_DEPTH=8, 10 branches with targets 0x100,0x104,… and no ready → 8 entries drain in order 0x100..0x11C, sel7=2, trc_overflow=1.
- Full plus simultaneous pop/push: FIFO full, ready=1 and a branch on the same edge → occupancy stays 8, DROPS unchanged, new record drains last.
- Saturation and clear: CNT_W=4, 20 enabled cycles → sel0=15 (0x0000000F). Assert clr coincident with branch_taken and snap → shadow holds 15; a second snap yields 0. FIFO empty, trc_overflow=0.
